// File: rtl/pipe_ex_ls_if.sv
// EXU -> LSU pipeline handshake bundle. The master modport belongs to the
// side that drives the EXU inputs and consumes the LSU outputs. The slave
// modport is the pipeline register itself.
interface pipe_ex_ls_if #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_AW    = 5,
    parameter int PC_W      = 64
);
    // EXU side (upstream)
    logic                 i_valid;
    logic                 o_ready;
    logic [PC_W-1:0]      i_pc;
    logic [CPU_WIDTH-1:0] i_exu_res;
    logic [CPU_WIDTH-1:0] i_regst;
    logic [2:0]           i_lsfunc3;
    logic                 i_lden;
    logic                 i_sten;
    logic                 i_rdwen;
    logic [REG_AW-1:0]    i_rdid;

    // LSU side (downstream)
    logic                 o_valid;
    logic                 i_ready;
    logic [PC_W-1:0]      o_pc;
    logic [CPU_WIDTH-1:0] o_addr;
    logic [CPU_WIDTH-1:0] o_regst;
    logic [2:0]           o_lsfunc3;
    logic                 o_lden;
    logic                 o_sten;
    logic                 o_rdwen;
    logic [REG_AW-1:0]    o_rdid;
    logic                 o_misalign;

    modport master (
        output i_valid, i_pc, i_exu_res, i_regst, i_lsfunc3,
               i_lden, i_sten, i_rdwen, i_rdid, i_ready,
        input  o_ready, o_valid, o_pc, o_addr, o_regst, o_lsfunc3,
               o_lden, o_sten, o_rdwen, o_rdid, o_misalign
    );

    modport slave (
        input  i_valid, i_pc, i_exu_res, i_regst, i_lsfunc3,
               i_lden, i_sten, i_rdwen, i_rdid, i_ready,
        output o_ready, o_valid, o_pc, o_addr, o_regst, o_lsfunc3,
               o_lden, o_sten, o_rdwen, o_rdid, o_misalign
    );
endinterface

// File: rtl/pipe_ex_ls.sv
// EXU -> LSU pipeline register with a two-entry skid buffer. The main entry
// drives the outputs. The skid entry absorbs one instruction when the LSU
// stalls, which lets o_ready be a pure register output. Memory and
// write-back enables are gated on bubbles and on misaligned accesses.
module pipe_ex_ls #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_AW    = 5,
    parameter int PC_W      = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    pipe_ex_ls_if.slave        bus
);
    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [CPU_WIDTH-1:0] addr;
        logic [CPU_WIDTH-1:0] regst;
        logic [2:0]           func3;
        logic                 lden;
        logic                 sten;
        logic                 rdwen;
        logic [REG_AW-1:0]    rdid;
        logic                 mis;
    } entry_t;

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_v;
    logic   r_skid_v;

    logic   w_acc;
    logic   w_deq;
    logic   w_mis;
    entry_t w_in;

    // Handshakes. o_ready depends only on registered state.
    assign w_acc = bus.i_valid & ~r_skid_v;
    assign w_deq = r_main_v & bus.i_ready;

    // Misalignment of the incoming access, judged by its access size.
    always_comb begin
        // NOTE: default first so that every path assigns w_mis; otherwise a latch is inferred.
        w_mis = 1'b0;
        if (bus.i_lden | bus.i_sten) begin
            case (bus.i_lsfunc3[1:0])
                2'b01:   w_mis = bus.i_exu_res[0];
                2'b10:   w_mis = |bus.i_exu_res[1:0];
                2'b11:   w_mis = |bus.i_exu_res[2:0];
                default: w_mis = 1'b0;
            endcase
        end
    end

    // Pack the incoming instruction into an entry.
    always_comb begin
        w_in       = '0;
        w_in.pc    = bus.i_pc;
        w_in.addr  = bus.i_exu_res;
        w_in.regst = bus.i_regst;
        w_in.func3 = bus.i_lsfunc3;
        w_in.lden  = bus.i_lden;
        w_in.sten  = bus.i_sten;
        w_in.rdwen = bus.i_rdwen;
        w_in.rdid  = bus.i_rdid;
        w_in.mis   = w_mis;
    end

    // Main/skid entry update: flush beats capture, skid refills main first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: data fields are reset too, so outputs read zero out of reset.
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (i_flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            // Skid full means o_ready is low, so no accept can arrive here.
            if (w_deq) begin
                // NOTE: non-blocking assignments let the skid read its old value while main takes it.
                r_main   <= r_skid;
                r_skid_v <= 1'b0;
            end
        end else if (!r_main_v || w_deq) begin
            r_main_v <= w_acc;
            if (w_acc) begin
                r_main <= w_in;
            end
        end else if (w_acc) begin
            r_skid   <= w_in;
            r_skid_v <= 1'b1;
        end
    end

    // Outputs: data is held as is, and enables are qualified by valid and alignment.
    always_comb begin
        bus.o_valid    = r_main_v;
        bus.o_ready    = ~r_skid_v;
        bus.o_pc       = r_main.pc;
        bus.o_addr     = r_main.addr;
        bus.o_regst    = r_main.regst;
        bus.o_lsfunc3  = r_main.func3;
        bus.o_rdid     = r_main.rdid;
        bus.o_sten     = r_main_v & r_main.sten  & ~r_main.mis;
        bus.o_lden     = r_main_v & r_main.lden  & ~r_main.mis;
        bus.o_rdwen    = r_main_v & r_main.rdwen & ~r_main.mis;
        bus.o_misalign = r_main_v & r_main.mis;
    end
endmodule

// File: tb/tb_pipe_ex_ls.sv
// Directed testbench for pipe_ex_ls: reset, streaming, backpressure,
// misalignment gating, flush, asynchronous reset and bubble gating.
module tb_pipe_ex_ls;
    localparam int CPU_WIDTH = 64;
    localparam int REG_AW    = 5;
    localparam int PC_W      = 64;

    logic clk;
    logic rst_n;
    logic flush;

    int n_checks;
    int n_errors;

    pipe_ex_ls_if #(.CPU_WIDTH(CPU_WIDTH), .REG_AW(REG_AW), .PC_W(PC_W)) bus ();

    pipe_ex_ls #(.CPU_WIDTH(CPU_WIDTH), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] addr, input logic [2:0] f3,
                         input logic ld, input logic st, input logic rdw, input logic [4:0] rd);
        bus.i_valid   = v;
        bus.i_pc      = 64'h1000 + addr;
        bus.i_exu_res = addr;
        bus.i_regst   = ~addr;
        bus.i_lsfunc3 = f3;
        bus.i_lden    = ld;
        bus.i_sten    = st;
        bus.i_rdwen   = rdw;
        bus.i_rdid    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        flush = 1'b0;
        bus.i_ready = 1'b0;
        idle();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
        n_checks++; if (bus.o_addr !== 64'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", bus.o_addr); end
        n_checks++; if (bus.o_pc !== 64'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", bus.o_pc); end
        n_checks++; if ({bus.o_sten, bus.o_lden, bus.o_rdwen, bus.o_misalign} !== 4'b0) begin
            n_errors++; $display("FAIL reset_enables: got %b want 0000",
                {bus.o_sten, bus.o_lden, bus.o_rdwen, bus.o_misalign}); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        logic [63:0] a;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 64'h8000_0000 + 64'(8 * k);
            drive(1'b1, a, 3'b011, 1'b0, 1'b1, 1'b0, 5'(k + 1));
            n_checks++; if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL stream_ready[%0d]: got %b want 1", k, bus.o_ready); end
            step();
            n_checks++; if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.o_valid); end
            n_checks++; if (bus.o_addr !== a) begin n_errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, bus.o_addr, a); end
            n_checks++; if (bus.o_regst !== ~a) begin n_errors++; $display("FAIL stream_regst[%0d]: got %h want %h", k, bus.o_regst, ~a); end
            n_checks++; if (bus.o_sten !== 1'b1) begin n_errors++; $display("FAIL stream_sten[%0d]: got %b want 1", k, bus.o_sten); end
            n_checks++; if (bus.o_rdid !== 5'(k + 1)) begin n_errors++; $display("FAIL stream_rdid[%0d]: got %0d want %0d", k, bus.o_rdid, k + 1); end
        end
        idle();
        step();
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_backpressure();
        bus.i_ready = 1'b0;
        drive(1'b1, 64'h10, 3'b011, 1'b0, 1'b1, 1'b0, 5'd1);
        step();
        n_checks++; if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_a: got %b want 1", bus.o_ready); end
        drive(1'b1, 64'h18, 3'b011, 1'b0, 1'b1, 1'b0, 5'd2);
        step();
        n_checks++; if (bus.o_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_full: got %b want 0", bus.o_ready); end
        n_checks++; if (bus.o_addr !== 64'h10) begin n_errors++; $display("FAIL bp_hold_a: got %h want 10", bus.o_addr); end
        // Input held valid while o_ready=0 must not be taken.
        drive(1'b1, 64'h20, 3'b011, 1'b0, 1'b1, 1'b0, 5'd3);
        step();
        n_checks++; if (bus.o_addr !== 64'h10) begin n_errors++; $display("FAIL bp_stall_a: got %h want 10", bus.o_addr); end
        idle();
        bus.i_ready = 1'b1;
        step();
        n_checks++; if (bus.o_addr !== 64'h18) begin n_errors++; $display("FAIL bp_emit_b: got %h want 18", bus.o_addr); end
        n_checks++; if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid_b: got %b want 1", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_again: got %b want 1", bus.o_ready); end
        step();
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_misalign();
        // {ld, st, f3, addr, expected misaligned}
        logic        t_ld  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        t_st  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  t_f3  [6] = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b000, 3'b011};
        logic [63:0] t_a   [6] = '{64'h8000_0002, 64'h8000_0004, 64'h8000_0001,
                                   64'h8000_0004, 64'h8000_0003, 64'h8000_0003};
        logic        t_mis [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        rdw;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rdw = ~t_st[k];
            drive(1'b1, t_a[k], t_f3[k], t_ld[k], t_st[k], rdw, 5'd7);
            step();
            n_checks++; if (bus.o_misalign !== t_mis[k]) begin n_errors++; $display("FAIL mis_flag[%0d]: got %b want %b", k, bus.o_misalign, t_mis[k]); end
            n_checks++; if (bus.o_lden !== (t_ld[k] & ~t_mis[k])) begin n_errors++; $display("FAIL mis_lden[%0d]: got %b want %b", k, bus.o_lden, t_ld[k] & ~t_mis[k]); end
            n_checks++; if (bus.o_sten !== (t_st[k] & ~t_mis[k])) begin n_errors++; $display("FAIL mis_sten[%0d]: got %b want %b", k, bus.o_sten, t_st[k] & ~t_mis[k]); end
            n_checks++; if (bus.o_rdwen !== (rdw & ~t_mis[k])) begin n_errors++; $display("FAIL mis_rdwen[%0d]: got %b want %b", k, bus.o_rdwen, rdw & ~t_mis[k]); end
        end
        idle();
        step();
        n_checks++; if (bus.o_misalign !== 1'b0) begin n_errors++; $display("FAIL mis_bubble: got %b want 0", bus.o_misalign); end
    endtask

    task automatic test_flush();
        bus.i_ready = 1'b0;
        drive(1'b1, 64'h100, 3'b011, 1'b0, 1'b1, 1'b0, 5'd1);
        step();
        drive(1'b1, 64'h108, 3'b011, 1'b0, 1'b1, 1'b0, 5'd2);
        step();
        n_checks++; if (bus.o_ready !== 1'b0) begin n_errors++; $display("FAIL flush_full: got %b want 0", bus.o_ready); end
        drive(1'b1, 64'h999, 3'b011, 1'b0, 1'b1, 1'b0, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready: got %b want 1", bus.o_ready); end
        n_checks++; if (bus.o_sten !== 1'b0) begin n_errors++; $display("FAIL flush_sten: got %b want 0", bus.o_sten); end
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL flush_ghost[%0d]: got valid %b addr %h want 0", k, bus.o_valid, bus.o_addr); end
        end
        // Main only full, o_ready high: an accept coincident with flush is discarded.
        bus.i_ready = 1'b0;
        drive(1'b1, 64'h400, 3'b011, 1'b0, 1'b1, 1'b0, 5'd4);
        step();
        drive(1'b1, 64'h408, 3'b011, 1'b0, 1'b1, 1'b0, 5'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        step();
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL flush_acc_drop: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_async_reset();
        bus.i_ready = 1'b1;
        drive(1'b1, 64'h200, 3'b011, 1'b0, 1'b1, 1'b0, 5'd1);
        step();
        n_checks++; if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL arst_pre_valid: got %b want 1", bus.o_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_sten !== 1'b0) begin n_errors++; $display("FAIL arst_sten: got %b want 0", bus.o_sten); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL arst_ready: got %b want 1", bus.o_ready); end
        step();
        rst_n = 1'b1;
        drive(1'b1, 64'h300, 3'b011, 1'b0, 1'b1, 1'b0, 5'd2);
        #2;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL arst_latency0: got %b want 0", bus.o_valid); end
        step();
        n_checks++; if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL arst_push_valid: got %b want 1", bus.o_valid); end
        n_checks++; if (bus.o_addr !== 64'h300) begin n_errors++; $display("FAIL arst_push_addr: got %h want 300", bus.o_addr); end
        idle();
        step();
    endtask

    task automatic test_bubble();
        bus.i_ready = 1'b1;
        drive(1'b1, 64'h500, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0);
        step();
        idle();
        n_checks++; if (bus.o_sten !== 1'b1) begin n_errors++; $display("FAIL bubble_store: got %b want 1", bus.o_sten); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL bubble_valid[%0d]: got %b want 0", k, bus.o_valid); end
            n_checks++; if (bus.o_sten !== 1'b0) begin n_errors++; $display("FAIL bubble_sten[%0d]: got %b want 0", k, bus.o_sten); end
            n_checks++; if (bus.o_addr !== 64'h500) begin n_errors++; $display("FAIL bubble_hold[%0d]: got %h want 500", k, bus.o_addr); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_misalign();
        test_flush();
        test_async_reset();
        test_bubble();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
